// File: rtl/kbd_scan_core.sv
// Keyboard matrix scanner and debouncer feeding the IRQ core.
// Walks a 64-entry scan address, tracks modifier/break lines and filters key bounce.
module kbd_scan_core #(
    parameter logic [5:0] CTRL_ADDR  = 6'h00,
    parameter logic [5:0] SHIFT_ADDR = 6'h10,
    parameter logic [5:0] BREAK_ADDR = 6'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scanTick,
    input  logic       kbdScanEn,
    input  logic       debounceEn,
    input  logic       kr1_n,
    input  logic       kr2_n,
    output logic [5:0] kbk,
    output logic [7:0] kbcode,
    output logic       setKey,
    output logic       setBreak,
    output logic       keyDown,
    output logic       shiftDown
);

    typedef enum logic [1:0] {IDLE, CONFIRM, KEYDOWN, RELEASE} state_t;

    state_t     state_q;
    logic [5:0] kbk_q, cmp_q;
    logic [7:0] kbcode_q;
    logic       setKey_q, setBreak_q, keyDown_q;
    logic       ctrl_q, shift_q, brk_q;
    logic       visit;

    assign visit = (kbk_q == cmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kbk_q      <= 6'd0;
            cmp_q      <= 6'd0;
            kbcode_q   <= 8'h00;
            setKey_q   <= 1'b0;
            setBreak_q <= 1'b0;
            keyDown_q  <= 1'b0;
            ctrl_q     <= 1'b0;
            shift_q    <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            setKey_q   <= 1'b0;
            setBreak_q <= 1'b0;
            if (!kbdScanEn) begin
                state_q   <= IDLE;
                keyDown_q <= 1'b0;
                ctrl_q    <= 1'b0;
                shift_q   <= 1'b0;
                brk_q     <= 1'b0;
            end else if (scanTick) begin
                kbk_q <= kbk_q + 6'd1;
                if (kbk_q == CTRL_ADDR)  ctrl_q  <= ~kr2_n;
                if (kbk_q == SHIFT_ADDR) shift_q <= ~kr2_n;
                if (kbk_q == BREAK_ADDR) begin
                    brk_q <= ~kr2_n;
                    // Edge only: a held BREAK must not repeat every scan.
                    if (!brk_q && !kr2_n) setBreak_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (!kr1_n) begin
                            cmp_q <= kbk_q;
                            if (debounceEn) begin
                                state_q <= CONFIRM;
                            end else begin
                                kbcode_q  <= {ctrl_q, shift_q, kbk_q};
                                setKey_q  <= 1'b1;
                                keyDown_q <= 1'b1;
                                state_q   <= KEYDOWN;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (visit) begin
                            if (!kr1_n) begin
                                kbcode_q  <= {ctrl_q, shift_q, cmp_q};
                                setKey_q  <= 1'b1;
                                keyDown_q <= 1'b1;
                                state_q   <= KEYDOWN;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    KEYDOWN: begin
                        if (visit && kr1_n) begin
                            if (debounceEn) begin
                                state_q <= RELEASE;
                            end else begin
                                state_q   <= IDLE;
                                keyDown_q <= 1'b0;
                            end
                        end
                    end
                    RELEASE: begin
                        // A press seen again here is bounce: back to KEYDOWN silently.
                        if (visit) begin
                            if (kr1_n) begin
                                state_q   <= IDLE;
                                keyDown_q <= 1'b0;
                            end else begin
                                state_q <= KEYDOWN;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign kbk       = kbk_q;
    assign kbcode    = kbcode_q;
    assign setKey    = setKey_q;
    assign setBreak  = setBreak_q;
    assign keyDown   = keyDown_q;
    assign shiftDown = shift_q;

endmodule

// File: tb/tb_kbd_scan_core.sv
// Directed table-driven bench for kbd_scan_core with a behavioural key matrix.
module tb_kbd_scan_core;

    localparam logic [5:0] CTRL_A  = 6'h00;
    localparam logic [5:0] SHIFT_A = 6'h10;
    localparam logic [5:0] BRK_A   = 6'h30;
    localparam int NR = 22;

    logic       clk, rst_n, scanTick, kbdScanEn, debounceEn, kr1_n, kr2_n;
    logic [5:0] kbk;
    logic [7:0] kbcode;
    logic       setKey, setBreak, keyDown, shiftDown;

    kbd_scan_core dut (
        .clk(clk), .rst_n(rst_n), .scanTick(scanTick), .kbdScanEn(kbdScanEn),
        .debounceEn(debounceEn), .kr1_n(kr1_n), .kr2_n(kr2_n), .kbk(kbk),
        .kbcode(kbcode), .setKey(setKey), .setBreak(setBreak), .keyDown(keyDown),
        .shiftDown(shiftDown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, deb, kon;
        logic [5:0] kaddr;
        logic       c, s, b;
        int         n;
        logic [5:0] e_kbk;
        logic [7:0] e_code;
        logic       e_kd, e_sd;
        int         e_sk, e_sb;
    } vec_t;

    vec_t rows[NR];

    int total = 0, bad = 0;
    int sk_cnt = 0, sb_cnt = 0, both_cnt = 0;
    logic       key_on, ctrl_on, shift_on, brk_on;
    logic [5:0] key_addr;

    always @(negedge clk) begin
        if (setKey) sk_cnt++;
        if (setBreak) sb_cnt++;
        if (setKey && setBreak) both_cnt++;
    end

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, got, exp);
        end
    endtask

    // Present the matrix response for the current address, then one tick and one idle cycle.
    task automatic tick();
        kr1_n = !(key_on && kbk == key_addr);
        kr2_n = !((ctrl_on && kbk == CTRL_A) || (shift_on && kbk == SHIFT_A) || (brk_on && kbk == BRK_A));
        scanTick = 1'b1;
        @(negedge clk);
        scanTick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int sk0, sb0;
        rows[0]  = '{1,1,0,6'h00,0,0,0,130, 6'h02,8'h00,0,0,0,0};
        rows[1]  = '{1,1,0,6'h00,0,0,0, 62, 6'h00,8'h00,0,0,0,0};
        rows[2]  = '{1,1,1,6'h15,0,1,0, 64, 6'h00,8'h00,0,1,0,0};
        rows[3]  = '{1,1,1,6'h15,0,1,0, 64, 6'h00,8'h55,1,1,1,0};
        rows[4]  = '{1,1,0,6'h15,0,1,0, 64, 6'h00,8'h55,1,1,0,0};
        rows[5]  = '{1,1,1,6'h15,0,1,0, 64, 6'h00,8'h55,1,1,0,0};
        rows[6]  = '{1,1,0,6'h15,0,1,0, 64, 6'h00,8'h55,1,1,0,0};
        rows[7]  = '{1,1,0,6'h15,0,1,0, 64, 6'h00,8'h55,0,1,0,0};
        rows[8]  = '{1,1,1,6'h15,0,0,0, 64, 6'h00,8'h55,0,0,0,0};
        rows[9]  = '{1,1,0,6'h15,0,0,0, 64, 6'h00,8'h55,0,0,0,0};
        rows[10] = '{1,1,0,6'h00,0,0,1, 64, 6'h00,8'h55,0,0,0,1};
        rows[11] = '{1,1,0,6'h00,0,0,1, 64, 6'h00,8'h55,0,0,0,0};
        rows[12] = '{1,1,0,6'h00,0,0,1, 64, 6'h00,8'h55,0,0,0,0};
        rows[13] = '{1,1,0,6'h00,0,0,0, 64, 6'h00,8'h55,0,0,0,0};
        rows[14] = '{1,1,0,6'h00,0,0,1, 64, 6'h00,8'h55,0,0,0,1};
        rows[15] = '{1,1,0,6'h00,0,0,0, 64, 6'h00,8'h55,0,0,0,0};
        rows[16] = '{1,0,1,6'h22,1,1,0, 64, 6'h00,8'hE2,1,1,1,0};
        rows[17] = '{1,0,1,6'h22,1,1,0, 10, 6'h0A,8'hE2,1,1,0,0};
        rows[18] = '{0,0,1,6'h22,1,1,0,  5, 6'h0A,8'hE2,0,0,0,0};
        rows[19] = '{1,1,0,6'h00,0,0,0, 54, 6'h00,8'hE2,0,0,0,0};
        rows[20] = '{1,0,1,6'h30,0,0,1, 64, 6'h00,8'h30,1,0,1,1};
        rows[21] = '{1,0,0,6'h30,0,0,0, 64, 6'h00,8'h30,0,0,0,0};

        rst_n = 1'b0; scanTick = 1'b0; kbdScanEn = 1'b1; debounceEn = 1'b1;
        kr1_n = 1'b1; kr2_n = 1'b1;
        key_on = 1'b0; ctrl_on = 1'b0; shift_on = 1'b0; brk_on = 1'b0; key_addr = 6'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_kbk", -1, 32'(kbk), 0);
        chk("rst_code", -1, 32'(kbcode), 0);
        chk("rst_flags", -1, {setKey, setBreak, keyDown, shiftDown}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < NR; r++) begin
            kbdScanEn = rows[r].en; debounceEn = rows[r].deb;
            key_on = rows[r].kon; key_addr = rows[r].kaddr;
            ctrl_on = rows[r].c; shift_on = rows[r].s; brk_on = rows[r].b;
            sk0 = sk_cnt; sb0 = sb_cnt;
            ticks(rows[r].n);
            chk("kbk", r, 32'(kbk), 32'(rows[r].e_kbk));
            chk("kbcode", r, 32'(kbcode), 32'(rows[r].e_code));
            chk("keyDown", r, 32'(keyDown), 32'(rows[r].e_kd));
            chk("shiftDown", r, 32'(shiftDown), 32'(rows[r].e_sd));
            chk("setKey_cnt", r, 32'(sk_cnt - sk0), 32'(rows[r].e_sk));
            chk("setBreak_cnt", r, 32'(sb_cnt - sb0), 32'(rows[r].e_sb));
        end
        chk("same_cycle_strobes", 20, 32'(both_cnt), 1);

        // Reset while a key sits in CONFIRM, then show no stale strobe afterwards.
        kbdScanEn = 1'b1; debounceEn = 1'b1;
        key_on = 1'b1; key_addr = 6'h05; ctrl_on = 1'b0; shift_on = 1'b0; brk_on = 1'b0;
        ticks(67);
        chk("pre_rst_kbk", 30, 32'(kbk), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_kbk", 30, 32'(kbk), 0);
        chk("async_code", 30, 32'(kbcode), 0);
        chk("async_flags", 30, {setKey, setBreak, keyDown, shiftDown}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sk0 = sk_cnt;
        ticks(64);
        chk("post_rst_nostrobe", 31, 32'(sk_cnt - sk0), 0);
        chk("post_rst_kd", 31, 32'(keyDown), 0);
        ticks(64);
        chk("post_rst_accept", 32, 32'(sk_cnt - sk0), 1);
        chk("post_rst_code", 32, 32'(kbcode), 32'h05);
        chk("post_rst_kd2", 32, 32'(keyDown), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
